// File: rtl/trace_capture_fifo.sv
// Timestamped trace of register writes and memory accesses, buffered in a
// FIFO and drained over valid/ready. Up to two events (REG, MEM) per cycle.
module trace_capture_fifo #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16,
  parameter int ENTRY_W = 2 + TS_W + ADDR_W + DATA_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         capture_en,
  input  logic                         reg_write_sig,
  input  logic [4:0]                   reg_num,
  input  logic [DATA_W-1:0]            reg_data,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W-1:0]            rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ENTRY_W-1:0]           out_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]        typ;
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, wptr1, rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;
  logic [16:0]       drop_sum;
  logic              pop, ev_reg, ev_mem;
  logic [1:0]        n_ev, n_push, n_drop;
  logic [CW:0]       free;
  entry_t            reg_e, mem_e;

  always_comb begin
    pop    = (cnt_q != '0) & out_ready;
    ev_reg = capture_en & reg_write_sig;
    ev_mem = capture_en & (wr | rd);
    n_ev   = {1'b0, ev_reg} + {1'b0, ev_mem};
    free   = DEPTH_L - {1'b0, cnt_q} + {{CW{1'b0}}, pop};
    // Short on space means free is 0 or 1; REG is older so it wins the slot.
    n_push = (free >= (CW+1)'(n_ev)) ? n_ev : free[1:0];
    n_drop = n_ev - n_push;

    reg_e.typ  = 2'b00;
    reg_e.ts   = ts_q;
    reg_e.idx  = ADDR_W'(reg_num);
    reg_e.data = reg_data;
    // {rd,wr} yields 01=MEMW, 10=MEMR, 11=CONFLICT directly.
    mem_e.typ  = {rd, wr};
    mem_e.ts   = ts_q;
    mem_e.idx  = addr;
    mem_e.data = wr ? wr_data : rd_data;

    wptr1    = wptr_q + 1'b1;
    wptr_d   = wptr_q + PW'(n_push);
    rptr_d   = rptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(n_push) - CW'(pop);
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d    = ovf_q | (n_drop != 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ts_q   <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ts_q   <= ts_q + 1'b1;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clk) begin
    if (reset && !clear && n_push != 2'd0) begin
      mem_q[wptr_q] <= ev_reg ? reg_e : mem_e;
      if (n_push == 2'd2) mem_q[wptr1] <= mem_e;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_entry  = mem_q[rptr_q];
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_trace_capture_fifo.sv
// Randomized and directed checks of trace_capture_fifo (DEPTH=4) against a
// queue-based model of the capture, drop and drain rules.
module tb_trace_capture_fifo;
  localparam int DATA_W = 32, ADDR_W = 9, DEPTH = 4, TS_W = 16;
  localparam int EW = 2 + TS_W + ADDR_W + DATA_W;
  typedef logic [EW-1:0] ent_t;

  logic              clk, reset, clear, capture_en, reg_write_sig, wr, rd, out_ready;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data, wr_data, rd_data;
  logic [ADDR_W-1:0] addr;
  logic              out_valid, overflow;
  logic [EW-1:0]     out_entry;
  logic [2:0]        count;
  logic [15:0]       drop_count;

  trace_capture_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .capture_en(capture_en),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  ent_t q[$];
  logic [TS_W-1:0] m_ts;
  logic            m_ovf;
  int              m_drop;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = '0; m_ovf = 1'b0; m_drop = 0;
  endtask

  task automatic add_ev(input ent_t e);
    if (q.size() < DEPTH) q.push_back(e);
    else begin
      m_ovf = 1'b1;
      if (m_drop < 16'hFFFF) m_drop++;
    end
  endtask

  task automatic model_step();
    logic [1:0]        t;
    logic [DATA_W-1:0] d;
    if (clear) model_reset();
    else begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (capture_en) begin
        if (reg_write_sig) add_ev({2'b00, m_ts, ADDR_W'(reg_num), reg_data});
        if (wr || rd) begin
          if (wr && rd)  begin t = 2'd3; d = wr_data; end
          else if (wr)   begin t = 2'd1; d = wr_data; end
          else           begin t = 2'd2; d = rd_data; end
          add_ev({t, m_ts, addr, d});
        end
      end
      m_ts = m_ts + 1'b1;
    end
  endtask

  // Called at a negedge: compare state, advance model with current inputs, wait a cycle.
  task automatic step();
    chk("valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drops", 64'(drop_count), 64'(m_drop));
    if (q.size() != 0) chk("entry", 64'(out_entry), 64'(q[0]));
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    clear = 0; capture_en = 1; reg_write_sig = 0; wr = 0; rd = 0;
    reg_num = '0; reg_data = '0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic ev_reg(input logic [4:0] n, input logic [31:0] d);
    reg_write_sig = 1; reg_num = n; reg_data = d;
  endtask

  initial begin
    idle(); out_ready = 0; reset = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    reset = 1;

    ev_reg(5'd1, 32'hA); step();                       // ts 0
    chk("first_ts", 64'(out_entry), 64'({2'b00, 16'd0, 9'd1, 32'hA}));
    idle(); out_ready = 1; step();                     // ts 1
    step();                                            // ts 2
    out_ready = 0; ev_reg(5'd5, 32'hDEADBEEF); step(); // ts 3
    chk("reg_entry", 64'(out_entry), 64'({2'b00, 16'd3, 9'd5, 32'hDEADBEEF}));
    chk("reg_count", 64'(count), 64'd1);
    idle(); out_ready = 1; ev_reg(5'd7, 32'h11);
    wr = 1; addr = 9'h1A; wr_data = 32'h22; step();    // ts 4
    chk("pair_reg", 64'(out_entry), 64'({2'b00, 16'd4, 9'd7, 32'h11}));
    idle(); step();
    chk("pair_mem", 64'(out_entry), 64'({2'b01, 16'd4, 9'h1A, 32'h22}));
    step();
    out_ready = 0; wr = 1; rd = 1; addr = 9'h40; wr_data = 32'h55; rd_data = 32'h99;
    step();                                            // ts 7
    chk("conflict", 64'(out_entry), 64'({2'b11, 16'd7, 9'h40, 32'h55}));
    chk("conf_count", 64'(count), 64'd1);
    idle(); out_ready = 1; step();

    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i % 2 == 0) ev_reg(5'(i), 32'(i));
      else begin rd = 1; addr = 9'(i); rd_data = 32'(100 + i); end
      step();
    end
    idle(); ev_reg(5'd9, 32'h9); wr = 1; addr = 9'h3; step();
    chk("full_count", 64'(count), 64'd4);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_drops", 64'(drop_count), 64'd2);
    out_ready = 1; step();
    chk("pop_count", 64'(count), 64'd4);
    chk("pop_drops", 64'(drop_count), 64'd3);

    idle(); reset = 0; #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_drops", 64'(drop_count), 64'd0);
    model_reset();
    @(negedge clk); reset = 1;
    step();
    out_ready = 0; ev_reg(5'd3, 32'h33); clear = 1; step();
    chk("clr_count", 64'(count), 64'd0);
    idle(); ev_reg(5'd2, 32'h77); step();
    chk("clr_ts", 64'(out_entry), 64'({2'b00, 16'd0, 9'd2, 32'h77}));

    for (int i = 0; i < 400; i++) begin
      clear         = ($urandom_range(0, 49) == 0);
      capture_en    = ($urandom_range(0, 9) != 0);
      reg_write_sig = $urandom_range(0, 1);
      reg_num       = 5'($urandom);
      reg_data      = $urandom;
      wr            = ($urandom_range(0, 2) == 0);
      rd            = ($urandom_range(0, 2) == 0);
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      out_ready     = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trace_capture_fifo.md
Name: trace_capture_fifo

Overview:
- Synthesizable event tracer for the RISC-V pipeline. It replaces simulation-only $display monitoring of register writes and data-memory accesses.
- Each register-file write and memory access becomes a timestamped trace entry. Entries are buffered in a parametrised FIFO and drained over a valid/ready port (bench scoreboard, debug UART, or on-chip logger).
- Two events can be captured per cycle.
- Read/write conflicts are flagged, and overflow is accounted for rather than silently lost.

Parameters:
- DATA_W, 32, width of reg_data/wr_data/rd_data.
- ADDR_W, 9, memory address width; also the index field width; must be >= 5.
- DEPTH, 16, FIFO entries; power of 2, >= 4.
- TS_W, 16, timestamp counter width.
- ENTRY_W, 2+TS_W+ADDR_W+DATA_W, derived; not to be overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset); deassertion is synchronous to clk.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- capture_en  in  1  when 0, no new events are captured; drain continues.
- reg_write_sig  in  1  register-file write strobe.
- reg_num  in  5  destination register.
- reg_data  in  DATA_W  register write value.
- wr  in  1  memory write strobe.
- rd  in  1  memory read strobe.
- addr  in  ADDR_W  memory address.
- wr_data  in  DATA_W  memory write value.
- rd_data  in  DATA_W  memory read value.
- out_valid  out  1  head entry is available.
- out_ready  in  1  consumer accepts the head entry.
- out_entry  out  ENTRY_W  head entry, packed {type[1:0], ts, idx, data}.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: at least one event was dropped.
- drop_count  out  16  dropped events; saturates at 0xFFFF.

Behaviour:
- Reset (reset=0), asynchronous: pointers, count, ts, overflow and drop_count all go to 0; out_valid=0. out_entry is don't-care while out_valid=0.
- Timestamp: ts increments every cycle, wrapping modulo 2^TS_W. An event sampled in cycle N carries the ts value held during cycle N (pre-increment). The first cycle after reset release has ts=0.
- Event decode per cycle, evaluated only when capture_en=1:
  - E_REG: reg_write_sig=1 → type 00, idx = zero-extended reg_num, data = reg_data.
  - E_MEM: wr=1, rd=0 → type 01 (MEMW), idx = addr, data = wr_data.
  - E_MEM: rd=1, wr=0 → type 10 (MEMR), idx = addr, data = rd_data.
  - E_MEM: wr=1, rd=1 → type 11 (CONFLICT), idx = addr, data = wr_data.
  - wr=0, rd=0 → no memory event.
- Push ordering: when both events occur in one cycle, E_REG is written first (older slot), then E_MEM.
- Free space: free = DEPTH - count + pop, where pop = out_valid & out_ready. Push count = min(number of events, free).
- Drops: if events exceed free, E_REG is kept and E_MEM is dropped. If free=0, both are dropped. Each dropped event sets overflow and adds 1 to drop_count (2 in one cycle when both drop), saturating at 0xFFFF.
- Latency: an entry pushed in cycle N appears at out_entry/out_valid in cycle N+1. It is not bypassed to the output in the same cycle.
- Output: out_valid = (count != 0). out_entry is the head slot and stays stable while out_valid=1 and out_ready=0. out_ready while out_valid=0 is ignored.
- Pointer arithmetic: read and write pointers are log2(DEPTH) bits and wrap naturally. count is updated as count + pushes - pop each cycle.
- clear=1 (synchronous): empties the FIFO and zeroes count, ts, overflow and drop_count. It overrides any push or pop in the same cycle; no event from that cycle is captured.
- capture_en=0: no pushes and no drop accounting; ts still runs.
- Reset asserted mid-operation: all state is lost immediately. No partial entry may remain visible after reset is released.

Test Plan:
- Reset → count=0, out_valid=0, overflow=0, drop_count=0; first post-reset event carries ts=0.
- reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF at ts=3 → next cycle out_valid=1, out_entry={00, 3, 5, 0xDEADBEEF}, count=1.
- Same cycle: reg_write_sig (x7=0x11) + wr=1 (addr=0x1A, wr_data=0x22), out_ready=1 → two entries drained in order: REG then MEMW, both with the same ts.
- wr=1 and rd=1 together, addr=0x40, wr_data=0x55 → single entry with type 11, idx 0x40, data 0x55.
- DEPTH=4, out_ready=0: 4 single events fill the FIFO, then a cycle with REG+MEM → both dropped, overflow=1, drop_count=2, count=4.
- Full FIFO, out_ready=1, REG+MEM in the same cycle → one pop, REG kept, MEM dropped, count stays 4, drop_count+1.
- Mid-drain, reset pulsed low for one cycle → count=0, out_valid=0 immediately; clear=1 during a push → no entry captured, ts=0 the next cycle.
